// File: rtl/nios_pio_irq.sv
// Parallel I/O port with output/direction registers, synchronized input,
// per-bit edge capture and a maskable interrupt for an Avalon-style slave bus.
module nios_pio_irq #(
  parameter int          DATA_W    = 9,
  parameter logic [31:0] RESET_VAL = 32'h0,
  parameter int          EDGE_TYPE = 0,
  parameter int          IRQ_TYPE  = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] oe,
  output logic              irq
);

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_DIR  = 3'd1;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_SET  = 3'd4;
  localparam logic [2:0] ADDR_CLR  = 3'd5;

  logic [DATA_W-1:0] out_q, out_d;
  logic [DATA_W-1:0] dir_q, dir_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] edge_q, edge_d;
  logic [DATA_W-1:0] s1_q, s2_q, p_q;
  logic [1:0]        warm_q, warm_d;

  logic              wr;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] w1c;
  logic [DATA_W-1:0] det;
  logic              det_en;
  logic [31:0]       rd;
  logic              unused_wd;

  function automatic logic [DATA_W-1:0] edge_detect(input logic [DATA_W-1:0] cur,
                                                    input logic [DATA_W-1:0] prev);
    case (EDGE_TYPE)
      1:       edge_detect = ~cur & prev;
      2:       edge_detect = cur ^ prev;
      default: edge_detect = cur & ~prev;
    endcase
  endfunction

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[DATA_W-1:0];
  assign unused_wd = &{1'b0, writedata};
  assign w1c       = (wr && address == ADDR_EDGE) ? wd : '0;
  assign det       = edge_detect(s2_q, p_q);
  // Synchronizer and previous-value flops come out of reset at zero; hold off
  // detection until they have been refilled from the pins.
  assign det_en    = (warm_q == 2'd3);

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    if (wr) begin
      case (address)
        ADDR_DATA: out_d  = wd;
        ADDR_DIR:  dir_d  = wd;
        ADDR_MASK: mask_d = wd;
        ADDR_SET:  out_d  = out_q | wd;
        ADDR_CLR:  out_d  = out_q & ~wd;
        default:   ;
      endcase
    end
    // A fresh detection overrides a simultaneous write-one-to-clear.
    edge_d = (edge_q & ~w1c) | (det_en ? det : '0);
    warm_d = det_en ? warm_q : warm_q + 2'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q  <= RESET_VAL[DATA_W-1:0];
      dir_q  <= '0;
      mask_q <= '0;
      edge_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      p_q    <= '0;
      warm_q <= 2'd0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      edge_q <= edge_d;
      s1_q   <= in_port;
      s2_q   <= s1_q;
      p_q    <= s2_q;
      warm_q <= warm_d;
    end
  end

  always_comb begin
    rd = '0;
    case (address)
      ADDR_DATA: rd[DATA_W-1:0] = (dir_q & out_q) | (~dir_q & s2_q);
      ADDR_DIR:  rd[DATA_W-1:0] = dir_q;
      ADDR_MASK: rd[DATA_W-1:0] = mask_q;
      ADDR_EDGE: rd[DATA_W-1:0] = edge_q;
      default:   rd = '0;
    endcase
  end

  assign readdata = rd;
  assign out_port = out_q;
  assign oe       = dir_q;

  generate
    if (IRQ_TYPE == 1) begin : g_irq_level
      assign irq = |(s2_q & mask_q);
    end else begin : g_irq_edge
      assign irq = |(edge_q & mask_q);
    end
  endgenerate

endmodule
